// File: rtl/ps2_tx_keyboard.sv
// PS/2 keyboard-side transmitter: queues key events and serialises them as
// E0/F0-prefixed scan-code frames, one bit per ps2_clk period.
module ps2_tx_keyboard #(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                          ps2_clk,
   input  logic                          clrn,
   input  logic                          ev_valid,
   input  logic [7:0]                    ev_code,
   input  logic                          ev_break,
   input  logic                          ev_ext,
   output logic                          ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          busy,
   output logic                          ps2_data,
   output logic                          clk_gate
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [1:0]    SEL_EXT  = 2'd0;
   localparam logic [1:0]    SEL_BRK  = 2'd1;
   localparam logic [1:0]    SEL_CODE = 2'd2;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   // Frame is held LSB-first: {stop, parity, data[7:0], start}
   function automatic logic [10:0] make_frame(input logic [7:0] b);
      return {1'b1, ~(^b), b, 1'b0};
   endfunction

   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   state_t        r_state, w_state_next;
   logic [3:0]    r_bit_cnt, w_bit_next;
   logic [GW-1:0] r_gap_cnt, w_gap_next;
   logic [10:0]   r_frame, w_frame_next;
   logic [1:0]    r_sel, w_sel_next;
   logic [7:0]    r_code, w_code_next;
   logic          r_brk, w_brk_next;

   logic          w_push, w_pop, w_full;
   logic [9:0]    w_head;
   logic [1:0]    w_head_sel;
   logic [7:0]    w_head_byte;

   assign w_full      = (r_count == FULL);
   assign w_push      = ev_valid && !w_full;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_sel  = w_head[9] ? SEL_EXT : (w_head[8] ? SEL_BRK : SEL_CODE);
   assign w_head_byte = w_head[9] ? 8'hE0 : (w_head[8] ? 8'hF0 : w_head[7:0]);

   always_ff @(posedge ps2_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {ev_ext, ev_break, ev_code};
   end

   always_ff @(posedge ps2_clk or negedge clrn) begin
      if (!clrn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A full FIFO drops the event even if a pop frees a slot this edge
         if (ev_valid && w_full) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge ps2_clk or negedge clrn) begin
      if (!clrn) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_frame   <= '1;
         r_sel     <= SEL_CODE;
         r_code    <= '0;
         r_brk     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_next;
         r_gap_cnt <= w_gap_next;
         r_frame   <= w_frame_next;
         r_sel     <= w_sel_next;
         r_code    <= w_code_next;
         r_brk     <= w_brk_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_bit_next   = r_bit_cnt;
      w_gap_next   = r_gap_cnt;
      w_frame_next = r_frame;
      w_sel_next   = r_sel;
      w_code_next  = r_code;
      w_brk_next   = r_brk;
      w_pop        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_state_next = SHIFT;
               w_bit_next   = '0;
               w_sel_next   = w_head_sel;
               w_code_next  = w_head[7:0];
               w_brk_next   = w_head[8];
               w_frame_next = make_frame(w_head_byte);
            end
         end
         SHIFT: begin
            if (r_bit_cnt == 4'd10) begin
               w_state_next = GAP;
               w_gap_next   = '0;
            end else begin
               w_bit_next   = r_bit_cnt + 4'd1;
               w_frame_next = {1'b1, r_frame[10:1]};
            end
         end
         GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_bit_next = '0;
               // Finish the current event's byte sequence before popping the next
               if (r_sel == SEL_EXT && r_brk) begin
                  w_state_next = SHIFT;
                  w_sel_next   = SEL_BRK;
                  w_frame_next = make_frame(8'hF0);
               end else if (r_sel != SEL_CODE) begin
                  w_state_next = SHIFT;
                  w_sel_next   = SEL_CODE;
                  w_frame_next = make_frame(r_code);
               end else if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_state_next = SHIFT;
                  w_sel_next   = w_head_sel;
                  w_code_next  = w_head[7:0];
                  w_brk_next   = w_head[8];
                  w_frame_next = make_frame(w_head_byte);
               end else begin
                  w_state_next = IDLE;
               end
            end else begin
               w_gap_next = r_gap_cnt + 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign ps2_data   = (r_state == SHIFT) ? r_frame[0] : 1'b1;
   assign clk_gate   = (r_state == SHIFT);
   assign busy       = (r_state != IDLE);
   assign ev_ready   = !w_full;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;
endmodule

// File: tb/tb_ps2_tx_keyboard.sv
// Directed bench for ps2_tx_keyboard: frame contents, prefixes, gaps,
// FIFO fill/overflow and asynchronous mid-frame reset.
module tb_ps2_tx_keyboard;
   localparam int DEPTH = 4;
   localparam int GAP   = 2;

   // Hand-computed frames written as {stop, parity, data[7:0], start}
   localparam logic [10:0] F_1C = 11'b1_0_00011100_0;
   localparam logic [10:0] F_F0 = 11'b1_1_11110000_0;
   localparam logic [10:0] F_E0 = 11'b1_0_11100000_0;
   localparam logic [10:0] F_75 = 11'b1_0_01110101_0;
   localparam logic [10:0] F_00 = 11'b1_1_00000000_0;
   localparam logic [10:0] F_32 = 11'b1_0_00110010_0;
   localparam logic [10:0] F_21 = 11'b1_1_00100001_0;
   localparam logic [10:0] F_23 = 11'b1_0_00100011_0;
   localparam logic [10:0] F_24 = 11'b1_1_00100100_0;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ev_valid = 1'b0;
   logic [7:0] ev_code = 8'h00;
   logic       ev_break = 1'b0;
   logic       ev_ext = 1'b0;
   logic       ev_ready, overflow, busy, ps2_data, clk_gate;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;

   ps2_tx_keyboard #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .ps2_clk(clk), .clrn(clrn), .ev_valid(ev_valid), .ev_code(ev_code),
      .ev_break(ev_break), .ev_ext(ev_ext), .ev_ready(ev_ready),
      .fifo_count(fifo_count), .overflow(overflow), .busy(busy),
      .ps2_data(ps2_data), .clk_gate(clk_gate)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; holds inputs across exactly one rising edge.
   task automatic push_ev(input logic [7:0] code, input logic brk, input logic ext);
      ev_valid = 1'b1;
      ev_code  = code;
      ev_break = brk;
      ev_ext   = ext;
      @(negedge clk);
      ev_valid = 1'b0;
      $display("push code=%02h brk=%0d ext=%0d count=%0d", code, brk, ext, fifo_count);
   endtask

   // Checks frame periods i0..10 then the idle-high gap that follows.
   task automatic check_frame(input string tag, input logic [10:0] f, input int i0);
      for (int i = i0; i < 11; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), ps2_data, f[i]);
         chk($sformatf("%s_gate%0d", tag, i), clk_gate, 1'b1);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
         @(negedge clk);
      end
      for (int g = 0; g < GAP; g++) begin
         chk($sformatf("%s_gapdata%0d", tag, g), ps2_data, 1'b1);
         chk($sformatf("%s_gapgate%0d", tag, g), clk_gate, 1'b0);
         chk($sformatf("%s_gapbusy%0d", tag, g), busy, 1'b1);
         @(negedge clk);
      end
      $display("frame %s checked (expected %03h)", tag, f);
   endtask

   task automatic expect_idle(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_data"}, ps2_data, 1'b1);
      chk({tag, "_gate"}, clk_gate, 1'b0);
   endtask

   initial begin
      logic [7:0] burst [6];
      burst = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_data", ps2_data, 1'b1);
      chk("rst_gate", clk_gate, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_count", fifo_count, 3'd0);
      chk("rst_ready", ev_ready, 1'b1);
      clrn = 1'b1;
      @(negedge clk);

      // Make 0x1C: queued for one edge, then popped with start bit next edge
      push_ev(8'h1C, 1'b0, 1'b0);
      chk("make_count1", fifo_count, 3'd1);
      chk("make_notbusy", busy, 1'b0);
      @(negedge clk);
      chk("make_count0", fifo_count, 3'd0);
      check_frame("make1C", F_1C, 0);
      expect_idle("make1C_end");

      // Break 0x1C: F0 then 1C
      push_ev(8'h1C, 1'b1, 1'b0);
      @(negedge clk);
      check_frame("brkF0", F_F0, 0);
      check_frame("brk1C", F_1C, 0);
      expect_idle("brk_end");

      // Extended break 0x75: E0, F0, 75
      push_ev(8'h75, 1'b1, 1'b1);
      @(negedge clk);
      check_frame("extE0", F_E0, 0);
      check_frame("extF0", F_F0, 0);
      check_frame("ext75", F_75, 0);
      expect_idle("ext_end");

      // Code 0x00 make
      push_ev(8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check_frame("make00", F_00, 0);
      expect_idle("make00_end");

      // Six pushes on consecutive edges: one pops, four fill, one dropped
      ev_valid = 1'b1;
      ev_break = 1'b0;
      ev_ext   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         ev_code = burst[k];
         @(negedge clk);
         $display("burst push %0d code=%02h count=%0d", k, burst[k], fifo_count);
      end
      ev_valid = 1'b0;
      chk("burst_count", fifo_count, 3'd4);
      chk("burst_ready", ev_ready, 1'b0);
      chk("burst_ovf", overflow, 1'b1);
      check_frame("burst1C", F_1C, 4);
      check_frame("burst32", F_32, 0);
      check_frame("burst21", F_21, 0);
      check_frame("burst23", F_23, 0);
      check_frame("burst24", F_24, 0);
      expect_idle("burst_end");
      chk("burst_empty", fifo_count, 3'd0);
      chk("ovf_sticky", overflow, 1'b1);

      // Asynchronous reset during data bit 4 with two events queued
      ev_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ev_code = burst[k];
         @(negedge clk);
      end
      ev_valid = 1'b0;
      chk("mid_count2", fifo_count, 3'd2);
      repeat (4) @(negedge clk);
      chk("mid_gate", clk_gate, 1'b1);
      chk("mid_bit4", ps2_data, 1'b1);
      clrn = 1'b0;
      #1;
      chk("arst_data", ps2_data, 1'b1);
      chk("arst_gate", clk_gate, 1'b0);
      chk("arst_count", fifo_count, 3'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_ovf", overflow, 1'b0);
      chk("arst_ready", ev_ready, 1'b1);
      $display("async reset applied mid-frame");
      @(negedge clk);
      clrn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         expect_idle($sformatf("post_rst%0d", c));
      end

      // Fresh event after reset still transmits
      push_ev(8'h23, 1'b0, 1'b0);
      @(negedge clk);
      check_frame("post23", F_23, 0);
      expect_idle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
